// File: rtl/sdram_fifo_pkg.sv
// Shared defaults and types for the SDRAM read/write data FIFOs.
// The write-side FIFO uses the same package, so names stay generic.
package sdram_fifo_pkg;

    localparam int SDRAM_WIDTH = 16;
    localparam int SDRAM_DEPTH = 64;
    localparam int SDRAM_AW    = 6;
    localparam int SDRAM_BURST = 8;

    // Per-cycle storage operation, encoded as {accepted write, accepted read}.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/sdram_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Written so that it maps onto a block RAM with a clearable output register.
module sdram_fifo_ram
    import sdram_fifo_pkg::*;
#(
    parameter int WIDTH = SDRAM_WIDTH,
    parameter int DEPTH = SDRAM_DEPTH,
    parameter int AW    = SDRAM_AW
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_d;
    logic [WIDTH-1:0] rd_data_q;

    // NOTE: the storage array is never reset; only the output register is
    // cleared, which keeps the array inferable as block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Same-address read and write in one cycle returns the old word.
    always_comb begin
        rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sdram_read_fifo.sv
// Return-path FIFO from SDRAM read capture to the Avalon read master, with
// a reservation counter that only grants a new burst when it is sure to fit.
module sdram_read_fifo
    import sdram_fifo_pkg::*;
#(
    parameter int WIDTH = SDRAM_WIDTH,
    parameter int DEPTH = SDRAM_DEPTH,
    parameter int AW    = SDRAM_AW,
    parameter int BURST = SDRAM_BURST
) (
    input  logic             clock,
    input  logic             sclr,
    input  logic             rd_valid,
    input  logic [WIDTH-1:0] rd_data,
    input  logic             burst_issue,
    output logic             burst_ok,
    input  logic             rdreq,
    output logic [WIDTH-1:0] q,
    output logic [AW:0]      usedw,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      pending,
    output logic             err
);

    localparam logic [AW:0]   DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW+1:0] BURST_W = (AW+2)'(BURST);
    localparam logic [AW+2:0] BURST_X = (AW+3)'(BURST);
    localparam logic [AW+2:0] DEPTH_X = (AW+3)'(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   usedw_q, usedw_d;
    logic [AW:0]   pending_q, pending_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          err_q, err_d;
    logic          burst_issue_q, burst_issue_d;

    logic          wr_en;
    logic          rd_en;
    fifo_op_e      op;
    logic [AW+1:0] pend_sum;
    logic [AW+2:0] reserved;
    logic          burst_ok_c;
    logic          drop_c;
    logic          unexpected_c;
    logic          bad_issue_c;

    // NOTE: every signal gets a value before any branch, so no latch can be
    // inferred; blocking '=' is correct here because this is combinational.
    always_comb begin
        rd_en  = rdreq && !empty_q;
        wr_en  = rd_valid && (!full_q || rd_en);
        op     = fifo_op_e'({wr_en, rd_en});
        wptr_d = wptr_q + AW'(wr_en);
        rptr_d = rptr_q + AW'(rd_en);

        usedw_d = usedw_q;
        case (op)
            FIFO_PUSH: usedw_d = usedw_q + 1'b1;
            FIFO_POP:  usedw_d = usedw_q - 1'b1;
            default:   usedw_d = usedw_q;
        endcase
        empty_d = (usedw_d == '0);
        full_d  = (usedw_d == DEPTH_P);

        // Reservation: add a burst on issue, retire one word per return,
        // never below zero and never above DEPTH.
        pend_sum = {1'b0, pending_q} + (burst_issue ? BURST_W : '0);
        if (rd_valid && (pend_sum != '0)) begin
            pend_sum = pend_sum - 1'b1;
        end
        pending_d = (pend_sum > {1'b0, DEPTH_P}) ? DEPTH_P : pend_sum[AW:0];

        // free >= BURST rewritten as usedw + pending + BURST <= DEPTH so the
        // comparison never goes negative.
        reserved   = {2'b00, usedw_q} + {2'b00, pending_q} + BURST_X;
        burst_ok_c = (reserved <= DEPTH_X) && !burst_issue_q;

        drop_c        = rd_valid && !wr_en;
        unexpected_c  = rd_valid && (pending_q == '0);
        bad_issue_c   = burst_issue && !burst_ok_c;
        err_d         = err_q || drop_c || unexpected_c || bad_issue_c;
        burst_issue_d = burst_issue;
    end

    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (sclr) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            usedw_q       <= '0;
            pending_q     <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            err_q         <= 1'b0;
            burst_issue_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            usedw_q       <= usedw_d;
            pending_q     <= pending_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            err_q         <= err_d;
            burst_issue_q <= burst_issue_d;
        end
    end

    sdram_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .sclr    (sclr),
        .wr_en   (wr_en),
        .wr_addr (wptr_q),
        .wr_data (rd_data),
        .rd_en   (rd_en),
        .rd_addr (rptr_q),
        .rd_data (q)
    );

    assign burst_ok = burst_ok_c;
    assign usedw    = usedw_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign pending  = pending_q;
    assign err      = err_q;

    // Internal invariants: counters in range, flags consistent, pointers track count.
    a_bounded: assert property (@(posedge clock) disable iff (sclr)
        (usedw_q <= DEPTH_P) && (pending_q <= DEPTH_P));
    a_flags: assert property (@(posedge clock) disable iff (sclr)
        (empty_q == (usedw_q == '0)) && (full_q == (usedw_q == DEPTH_P)));
    a_ptrs: assert property (@(posedge clock) disable iff (sclr)
        (AW'(wptr_q - rptr_q) == usedw_q[AW-1:0]));

endmodule

// File: doc/sdram_read_fifo.md
# sdram_read_fifo

Return-path buffer between the SDRAM controller's read-data capture and the NIOS/Avalon read master. It is the read-direction counterpart of the write FIFO feeding the controller. It stores 16-bit words arriving one per `rd_valid`, presents them to the consumer with a one-cycle registered read, and tracks words already requested but not yet arrived. It grants the controller permission to issue a new read burst only when the FIFO is guaranteed to absorb the whole burst.

## Interface

Parameters:
- `WIDTH`, 16: data word width.
- `DEPTH`, 64: FIFO words; power of two.
- `AW`, 6: log2(DEPTH).
- `BURST`, 8: words per controller read burst; must be 1..DEPTH.

Ports:
- `clock` in 1: single clock; all logic on its rising edge.
- `sclr` in 1: reset, synchronous, active-high.
- `rd_valid` in 1: controller returns one SDRAM read word this cycle.
- `rd_data` in WIDTH: returned word, qualified by `rd_valid`.
- `burst_issue` in 1: one-cycle pulse; controller has just issued a BURST-word read.
- `burst_ok` out 1: controller may issue a burst this cycle.
- `rdreq` in 1: consumer pops one word.
- `q` out WIDTH: popped word, valid the cycle after an accepted `rdreq`.
- `usedw` out AW+1: words stored, 0..DEPTH.
- `empty` out 1: `usedw == 0`.
- `full` out 1: `usedw == DEPTH`.
- `pending` out AW+1: words requested but not yet returned.
- `err` out 1: sticky protocol error; cleared only by `sclr`.

## Operation

- Storage: circular buffer with AW-bit write and read pointers. Pointers wrap naturally DEPTH-1 -> 0. The count register is AW+1 bits wide.
- Write: accepted when `rd_valid` and (!full or an accepted pop in the same cycle). Word stored at wptr; wptr increments.
- Read: accepted when `rdreq` and !empty. Word at rptr is loaded into `q` the next cycle; rptr increments. `rdreq` while empty is ignored: `q` holds and no error is raised. `q` holds its value whenever no read is accepted (non-showahead).
- Simultaneous accepted write and read: count unchanged. A write to a full FIFO with a simultaneous accepted pop is legal.
- `rd_valid` while full with no pop: word dropped, count unchanged, `err` set.
- Reservation:
  - `pending` next = pending + (burst_issue ? BURST : 0) - (rd_valid ? 1 : 0). Both events in one cycle give net +BURST-1.
  - `rd_valid` with pending == 0: `pending` stays 0 (saturate), `err` set, word still written if space allows.
  - `pending` saturates at DEPTH.
- Credit: free = DEPTH - usedw - pending, computed from registered values. `burst_ok` = (free >= BURST) and !burst_issue_q, where burst_issue_q is `burst_issue` delayed one cycle. This blocks back-to-back issue before counts settle.
- `burst_issue` while `burst_ok` is low: reservation still added, `err` set.
- `sclr` mid-burst discards stored data and outstanding reservations. Words returned after reset are treated as unexpected (`err`).

## Timing

- Reset values: `q`=0, `usedw`=0, `empty`=1, `full`=0, `pending`=0, `err`=0, `burst_ok`=1, pointers 0, burst_issue_q=0.
- Write-to-visible latency: `usedw`/`empty` update the cycle after `rd_valid`. The earliest accepted `rdreq` is that cycle, and `q` follows one cycle later.
- Read latency: `q` valid exactly 1 cycle after an accepted `rdreq`.
- `burst_ok` is low for at least the cycle after any `burst_issue`, then reflects the updated counts.
- `full`, `empty`, `usedw`, `pending` and `err` are registered. `burst_ok` is combinational from registers only, with no input-to-output path.

## Structure

- Package `sdram_fifo_pkg`: WIDTH, DEPTH, AW, BURST defaults; shared with the write-side FIFO.
- Sub-module `sdram_fifo_ram`: simple dual-port RAM, DEPTH x WIDTH, one write port, registered read port. This maps to M10K.
- Top level holds the pointers, count, reservation counter, credit logic and error flag.

## Test plan

- After reset, `burst_issue` once, then 8 `rd_valid` with data 0x1000..0x1007 -> `pending` 8 -> 0, `usedw`=8; 8 `rdreq` -> `q` = 0x1000..0x1007, one cycle after each pop, `empty`=1 at end.
- Eight bursts back-to-back, issued as soon as `burst_ok` allows, with no pops -> `burst_ok` low after the 8th (free 0), all 64 words stored, `full`=1, `err`=0.
- Full FIFO, `rd_valid` with 0xBEEF and `rdreq` in the same cycle -> `usedw` stays 64, 0xBEEF read last, `err`=0. Same without `rdreq` -> word dropped, `err`=1.
- `rdreq` on empty for 3 cycles -> `q` unchanged, `usedw`=0, `err`=0.
- `rd_valid` with `pending`=0 -> `err`=1, word stored. `burst_issue` while `burst_ok`=0 -> `pending` +8, `err`=1.
- `sclr` with `usedw`=20, `pending`=5 -> next cycle all outputs at reset values, `burst_ok`=1.
